// File: rtl/afe_attn_spi.sv
// rtl/afe_attn_spi.sv - CSR-driven serial writer for the AFE step attenuators
// One accepted CSR write shifts a word MSB first into one board, then pulses its latch enable.
module afe_attn_spi #(
   parameter int AFE_COUNT = 2,
   parameter int BITCOUNT  = 8,
   parameter int CLK_DIV   = 5
) (
   input  logic                 sysClk,
   input  logic                 sysReset,
   input  logic                 csrStrobe,
   input  logic [31:0]          GPIO_OUT,
   output logic [31:0]          status,
   output logic [AFE_COUNT-1:0] spiClk,
   output logic [AFE_COUNT-1:0] spiSDI,
   output logic [AFE_COUNT-1:0] spiLE
);

   localparam int TW = $clog2(CLK_DIV + 1);
   localparam int CW = $clog2(BITCOUNT);
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLK_DIV - 1);
   localparam logic [8:0]    AFE_LIMIT    = 9'(AFE_COUNT);

   typedef enum logic [2:0] {
      IDLE, SHIFT_LO, SHIFT_HI, LE_SETUP, LE_PULSE, HOLDOFF
   } state_t;

   state_t                 state_q, state_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [CW-1:0]          bitcnt_q, bitcnt_d;
   logic [BITCOUNT-1:0]    shreg_q, shreg_d;
   logic [BITCOUNT-1:0]    word_q, word_d;
   logic [7:0]             sel_q, sel_d;
   logic                   overrun_q, overrun_d;
   logic                   badsel_q, badsel_d;
   logic [AFE_COUNT-1:0]   clk_q, clk_d;
   logic [AFE_COUNT-1:0]   sdi_q, sdi_d;
   logic [AFE_COUNT-1:0]   le_q, le_d;
   logic                   sel_ok;
   logic                   timer_done;
   logic                   gpio_unused;

   assign gpio_unused = ^GPIO_OUT;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      word_d     = word_q;
      sel_d      = sel_q;
      overrun_d  = overrun_q;
      badsel_d   = badsel_q;
      clk_d      = '0;
      sdi_d      = '0;
      le_d       = '0;
      sel_ok     = ({1'b0, GPIO_OUT[23:16]} < AFE_LIMIT);
      timer_done = (timer_q == '0);

      if (state_q != IDLE) begin
         timer_d = timer_q - TW'(1);
         if (csrStrobe) overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (csrStrobe) begin
               if (sel_ok) begin
                  state_d   = SHIFT_LO;
                  timer_d   = TIMER_RELOAD;
                  shreg_d   = GPIO_OUT[BITCOUNT-1:0];
                  bitcnt_d  = CW'(BITCOUNT - 1);
                  word_d    = GPIO_OUT[BITCOUNT-1:0];
                  sel_d     = GPIO_OUT[23:16];
                  overrun_d = 1'b0;
                  badsel_d  = 1'b0;
               end else begin
                  badsel_d  = 1'b1;
               end
            end
         end
         SHIFT_LO: if (timer_done) begin
            state_d = SHIFT_HI;
            timer_d = TIMER_RELOAD;
         end
         SHIFT_HI: if (timer_done) begin
            timer_d = TIMER_RELOAD;
            if (bitcnt_q == '0) begin
               state_d = LE_SETUP;
            end else begin
               // Shifting on the HI->LO transition keeps SDI changing only on SCLK falls.
               state_d  = SHIFT_LO;
               shreg_d  = shreg_q << 1;
               bitcnt_d = bitcnt_q - CW'(1);
            end
         end
         LE_SETUP: if (timer_done) begin
            state_d = LE_PULSE;
            timer_d = TIMER_RELOAD;
         end
         LE_PULSE: if (timer_done) begin
            state_d = HOLDOFF;
            timer_d = TIMER_RELOAD;
         end
         HOLDOFF: if (timer_done) begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Pins are registered from the next state so they line up with the state itself.
      for (int i = 0; i < AFE_COUNT; i++) begin
         if (sel_d == 8'(i)) begin
            case (state_d)
               SHIFT_LO: sdi_d[i] = shreg_d[BITCOUNT-1];
               SHIFT_HI: begin
                  clk_d[i] = 1'b1;
                  sdi_d[i] = shreg_d[BITCOUNT-1];
               end
               LE_PULSE: le_d[i] = 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
         word_q    <= '0;
         sel_q     <= '0;
         overrun_q <= 1'b0;
         badsel_q  <= 1'b0;
         clk_q     <= '0;
         sdi_q     <= '0;
         le_q      <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         word_q    <= word_d;
         sel_q     <= sel_d;
         overrun_q <= overrun_d;
         badsel_q  <= badsel_d;
         clk_q     <= clk_d;
         sdi_q     <= sdi_d;
         le_q      <= le_d;
      end
   end

   always_comb begin
      status                 = '0;
      status[31]             = (state_q != IDLE);
      status[30]             = overrun_q;
      status[29]             = badsel_q;
      status[23:16]          = sel_q;
      status[BITCOUNT-1:0]   = word_q;
   end

   assign spiClk = clk_q;
   assign spiSDI = sdi_q;
   assign spiLE  = le_q;

endmodule

// File: tb/tb_afe_attn_spi.sv
// tb/tb_afe_attn_spi.sv - directed bench for afe_attn_spi
// Two instances: defaults, and CLK_DIV=2 / BITCOUNT=16.
module tb_afe_attn_spi;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, stb2;
   logic [31:0] gpio, gpio2;
   logic [31:0] status, status2;
   logic [1:0]  sclk, sdi, le;
   logic [1:0]  sclk2, sdi2, le2;

   int checks = 0;
   int errors = 0;
   int cyc;
   int rise_c[$];
   logic rise_d[$];
   int le_c[$];

   always #5 clk = ~clk;

   afe_attn_spi dut (
      .sysClk(clk), .sysReset(rst), .csrStrobe(stb), .GPIO_OUT(gpio),
      .status(status), .spiClk(sclk), .spiSDI(sdi), .spiLE(le)
   );

   afe_attn_spi #(.AFE_COUNT(2), .BITCOUNT(16), .CLK_DIV(2)) dut2 (
      .sysClk(clk), .sysReset(rst), .csrStrobe(stb2), .GPIO_OUT(gpio2),
      .status(status2), .spiClk(sclk2), .spiSDI(sdi2), .spiLE(le2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {busy, sclk, sdi, le} for cycle c after a strobe on cycle 0
   function automatic logic [3:0] model(input int c, input logic [15:0] w, input int d, input int b);
      int n;
      int p;
      n = c - 1;
      if (c < 1 || n >= (2 * b + 3) * d) return 4'b0000;
      p = n / d;
      if (p < 2 * b) return {1'b1, p[0], w[b - 1 - p / 2], 1'b0};
      if (p == 2 * b + 1) return 4'b1001;
      return 4'b1000;
   endfunction

   // Strobes on cycle 0 (and on cycle ovr), checks pins and busy on cycles cyc..last.
   task automatic follow(input int last, input logic [15:0] w, input int sel, input int ovr);
      logic [3:0] m;
      logic [1:0] e_clk, e_sdi, e_le;
      logic prev;
      rise_c.delete();
      rise_d.delete();
      le_c.delete();
      prev = 1'b0;
      while (cyc <= last) begin
         m = model(cyc, w, 5, 8);
         e_clk = '0; e_sdi = '0; e_le = '0;
         e_clk[sel] = m[2];
         e_sdi[sel] = m[1];
         e_le[sel]  = m[0];
         chk($sformatf("busy@%0d", cyc), {31'd0, status[31]}, {31'd0, m[3]});
         chk($sformatf("sclk@%0d", cyc), {30'd0, sclk}, {30'd0, e_clk});
         chk($sformatf("sdi@%0d", cyc), {30'd0, sdi}, {30'd0, e_sdi});
         chk($sformatf("le@%0d", cyc), {30'd0, le}, {30'd0, e_le});
         if (sclk[sel] && !prev) begin
            rise_c.push_back(cyc);
            rise_d.push_back(sdi[sel]);
         end
         if (le[sel]) le_c.push_back(cyc);
         prev = sclk[sel];
         stb = (cyc == 0) || (cyc == ovr);
         tick();
      end
      stb = 1'b0;
   endtask

   initial begin
      logic [7:0] a5;
      int pulses, hi_run, bad_runs, busy_cnt, first_busy, last_busy;
      logic [3:0] m2;

      rst = 1'b1; stb = 1'b0; stb2 = 1'b0; gpio = '0; gpio2 = '0; cyc = 0;
      tick(); tick(); tick();
      chk("reset_status", status, 32'h0);
      chk("reset_pins", {26'd0, sclk, sdi, le}, 32'h0);
      rst = 1'b0;
      tick();
      chk("idle_status", status, 32'h0);

      // Select 1, word 0xA5
      gpio = 32'h0001_00A5; cyc = 0;
      follow(100, 16'h00A5, 1, -1);
      chk("t1_rises", rise_c.size(), 8);
      a5 = 8'hA5;
      for (int k = 0; k < 8 && k < rise_c.size(); k++) begin
         chk($sformatf("t1_rise%0d_cyc", k), rise_c[k], 6 + 10 * k);
         chk($sformatf("t1_rise%0d_sdi", k), {31'd0, rise_d[k]}, {31'd0, a5[7 - k]});
      end
      chk("t1_le_len", le_c.size(), 5);
      if (le_c.size() > 0) chk("t1_le_first", le_c[0], 86);
      chk("t1_status", status, 32'h0001_00A5);

      // Select 0, word 0x3C, overrun strobe on cycle 40
      gpio = 32'h0000_003C; cyc = 0;
      follow(100, 16'h003C, 0, 40);
      chk("t2_rises", rise_c.size(), 8);
      chk("t2_status_ovr", status, 32'h4000_003C);

      // Bad select: no activity, previous select/word retained
      gpio = 32'h0002_0011; stb = 1'b1;
      tick();
      stb = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("t3_pins%0d", i), {26'd0, sclk, sdi, le}, 32'h0);
         chk($sformatf("t3_status%0d", i), status, 32'h6000_003C);
         tick();
      end

      // Accepted write clears flags; strobe on the cycle busy falls is accepted
      gpio = 32'h0001_0081; cyc = 0;
      follow(95, 16'h0081, 1, -1);
      chk("t4_status", status, 32'h0001_0081);
      gpio = 32'h0000_00C3; cyc = 0;
      follow(95, 16'h00C3, 0, 95);
      chk("t5_rises", rise_c.size(), 8);
      chk("t5_status_ovr95", status, 32'h4000_00C3);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t5_idle%0d", i), {26'd0, sclk, sdi, le, 1'b0, status[31]}, 32'h0);
         tick();
      end

      // Reset mid-transaction at cycle 30
      gpio = 32'h0001_005A; cyc = 0;
      follow(29, 16'h005A, 1, -1);
      rst = 1'b1;
      tick();
      chk("t6_pins", {26'd0, sclk, sdi, le}, 32'h0);
      chk("t6_status", status, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 80; i++) begin
         chk($sformatf("t6_quiet%0d", i), {30'd0, le | sclk}, 32'h0);
         tick();
      end

      // Reset wins over a simultaneous strobe
      gpio = 32'h0000_0055; rst = 1'b1; stb = 1'b1;
      tick();
      rst = 1'b0; stb = 1'b0;
      chk("t7_busy", status, 32'h0);
      tick();
      chk("t7_busy_after", status, 32'h0);

      // CLK_DIV=2, BITCOUNT=16, word 0xFFFF
      gpio2 = 32'h0000_FFFF; stb2 = 1'b1; cyc = 0;
      tick();
      stb2 = 1'b0;
      pulses = 0; hi_run = 0; bad_runs = 0; busy_cnt = 0; first_busy = -1; last_busy = -1;
      while (cyc <= 80) begin
         m2 = model(cyc, 16'hFFFF, 2, 16);
         chk($sformatf("d2_sclk@%0d", cyc), {30'd0, sclk2}, {31'd0, m2[2]});
         chk($sformatf("d2_le@%0d", cyc), {30'd0, le2}, {31'd0, m2[0]});
         if (sclk2[0]) begin
            if (hi_run == 0) pulses++;
            hi_run++;
         end else begin
            if (hi_run != 0 && hi_run != 2) bad_runs++;
            hi_run = 0;
         end
         if (status2[31]) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = cyc;
            last_busy = cyc;
         end
         tick();
      end
      chk("d2_pulses", pulses, 16);
      chk("d2_bad_runs", bad_runs, 0);
      chk("d2_busy_cnt", busy_cnt, 70);
      chk("d2_first_busy", first_busy, 1);
      chk("d2_last_busy", last_busy, 70);
      chk("d2_status", status2, 32'h0000_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
